touch_pad_reader: RTL
=====================

Name: touch_pad_reader

Overview:
- Input-side counterpart to the LED driver path: samples the conductive touch pads (user_1, user_4, pulled low when bridged to their driven-0 partner pins).
- Synchronises, debounces and classifies each pad into PRESS / RELEASE / LONG events.
- Queues events in a small FIFO behind a valid/ready interface for the consuming logic (LED pattern selector, mode FSM).

Parameters:
NUM_PADS, 2, number of pad inputs
ACTIVE_LOW, 1, 1: pad touched when pin reads 0; 0: touched when pin reads 1
DEBOUNCE_CYCLES, 480000, consecutive stable cycles to accept a level change (10 ms at 48 MHz); must be >= 2*NUM_PADS
LONG_CYCLES, 48000000, cycles from accepted press to LONG event (1 s); must be > DEBOUNCE_CYCLES
FIFO_DEPTH, 4, event FIFO entries, power of two

Ports:
clk  input  1  system clock, 48 MHz, from global buffer
rst  input  1  synchronous active-high reset
pad_in  input  NUM_PADS  raw asynchronous pad pins
pressed  output  NUM_PADS  debounced touched level per pad
evt_valid  output  1  FIFO head holds an event
evt_ready  input  1  consumer accepts head when evt_valid&&evt_ready
evt_pad  output  clog2(NUM_PADS) (min 1)  pad index of head event
evt_code  output  2  00 PRESS, 01 RELEASE, 10 LONG; 11 never emitted
overflow  output  1  sticky: an event was dropped because the FIFO was full

Behaviour:
- Reset (rst=1 at posedge):
  - Outputs: pressed=0, evt_valid=0, evt_pad=0, evt_code=0, overflow=0.
  - Internal state: FIFO empty, all pad FSMs IDLE, counters 0, pending flags clear, synchroniser flops loaded with the inactive level.
  - Reset mid-operation discards queued and pending events.
- Input conditioning:
  - Each pad passes through a 2-flop synchroniser.
  - Polarity is normalised to act (1 = touched) after synchronisation.
  - A pin change sampled at edge N is visible as act at edge N+2.
- Per-pad FSM (states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT), debounce counter dcnt, long counter lcnt:
  - IDLE: act=1 -> PRESS_WAIT, dcnt=1.
  - PRESS_WAIT:
    - act=0 -> IDLE, dcnt=0.
    - act=1 and dcnt==DEBOUNCE_CYCLES-1 -> HELD, pressed=1, raise PRESS, lcnt=0.
    - Otherwise dcnt++.
  - HELD: act=0 -> RELEASE_WAIT, dcnt=1.
  - RELEASE_WAIT:
    - act=1 -> HELD, dcnt=0.
    - act=0 and dcnt==DEBOUNCE_CYCLES-1 -> IDLE, pressed=0, raise RELEASE.
    - Otherwise dcnt++.
  - lcnt: increments every cycle in HELD and RELEASE_WAIT, saturating at LONG_CYCLES.
    - Reaching LONG_CYCLES raises LONG exactly once per press.
    - If LONG and RELEASE coincide in the same cycle, LONG is raised first and RELEASE moves to pending for the following cycle.
  - Net latency: a clean touch at edge N gives pressed=1 at edge N+2+DEBOUNCE_CYCLES.
- Event arbitration:
  - Each pad has a 1-deep pending register.
  - Each cycle, the lowest-index pad with a pending or newly raised event is pushed to the FIFO; the others stay pending.
  - The DEBOUNCE_CYCLES >= 2*NUM_PADS constraint guarantees pending registers never overrun.
- FIFO:
  - Registered; a push at edge N is visible on evt_* at edge N+1 if the FIFO was empty.
  - Pop on evt_valid&&evt_ready.
  - Push and pop in the same cycle are both honoured, including when full: the pop frees the slot, so no overflow.
  - Push when full with no pop: the event is dropped, overflow is set to 1 and stays 1 until rst.
  - Pointers wrap modulo FIFO_DEPTH; a full/empty distinction is required.
  - evt_pad and evt_code are held stable while evt_valid=1 and evt_ready=0.

Test Plan:
- Settings for all scenarios: DEBOUNCE_CYCLES=4, LONG_CYCLES=16, FIFO_DEPTH=4, ACTIVE_LOW=1.
- Clean touch: pad_in[0] 1->0 at edge 10, evt_ready=1 -> pressed[0]=1 at edge 16; evt_valid=1, evt_pad=0, evt_code=00 at edge 17.
- Bounce: pad_in[0] low for 3 cycles, high 1, low 3, high -> pressed never asserts, no events.
- Long press: pad_in[1] held low 30 cycles, then released -> events in order PRESS, LONG (16 cycles after pressed rose), RELEASE; pressed[1] falls 6 cycles after release edge.
- Simultaneous: both pads touched on the same edge -> PRESS pad0 then PRESS pad1 on consecutive cycles.
- Backpressure: evt_ready=0, generate 5 events -> first 4 held in order, overflow=1; then evt_ready=1 drains exactly 4 events; overflow stays 1 until rst.
- Reset mid-press: rst at PRESS_WAIT dcnt=2 -> pressed=0, evt_valid=0; a still-low pad re-debounces fully after rst drops.

Source files
------------

// File: rtl/touch_pad_reader_if.sv
`default_nettype none
// ============================================================================
// Module   : touch_pad_reader_if
// Purpose  : Event stream from the touch pad reader to its consumer.
//            The head of the event FIFO is presented with a valid/ready
//            handshake; an event is taken when evt_valid && evt_ready.
// Signals  : evt_valid - head holds an event        (master -> slave)
//            evt_ready - consumer accepts the head  (slave  -> master)
//            evt_pad   - pad index of head event    (master -> slave)
//            evt_code  - 00 PRESS, 01 RELEASE, 10 LONG (master -> slave)
// Revision : 1.0 - initial release
// ============================================================================
interface touch_pad_reader_if #(
    parameter int PAD_W = 1
);
    logic             evt_valid;
    logic             evt_ready;
    logic [PAD_W-1:0] evt_pad;
    logic [1:0]       evt_code;

    modport master (output evt_valid, output evt_pad, output evt_code, input evt_ready);
    modport slave  (input evt_valid, input evt_pad, input evt_code, output evt_ready);
endinterface
`default_nettype wire

// File: rtl/touch_pad_reader.sv
`default_nettype none
// ============================================================================
// Module   : touch_pad_reader
// Purpose  : Samples conductive touch pads, synchronises and debounces each
//            one, classifies PRESS / RELEASE / LONG events and queues them in
//            a small FIFO for the consuming logic.
// Ports    : clk      - system clock
//            rst      - synchronous active-high reset
//            pad_in   - raw asynchronous pad pins
//            pressed  - debounced touched level per pad
//            evt      - event stream (valid/ready, pad index, event code)
//            overflow - sticky: an event was dropped on a full FIFO
// Revision : 1.0 - initial release
// ============================================================================
module touch_pad_reader #(
    parameter int NUM_PADS        = 2,
    parameter int ACTIVE_LOW      = 1,
    parameter int DEBOUNCE_CYCLES = 480000,
    parameter int LONG_CYCLES     = 48000000,
    parameter int FIFO_DEPTH      = 4,
    parameter int PAD_W           = (NUM_PADS > 1) ? $clog2(NUM_PADS) : 1
) (
    input  wire                     clk,
    input  wire                     rst,
    input  wire  [NUM_PADS-1:0]     pad_in,
    output logic [NUM_PADS-1:0]     pressed,
    touch_pad_reader_if.master      evt,
    output logic                    overflow
);

    localparam int c_DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int c_LW = $clog2(LONG_CYCLES + 1);
    localparam int c_AW = $clog2(FIFO_DEPTH);

    localparam logic [c_DW-1:0] c_DB_LAST   = c_DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_DW-1:0] c_DCNT_ONE  = c_DW'(1);
    localparam logic [c_LW-1:0] c_LONG_LAST = c_LW'(LONG_CYCLES - 1);
    localparam logic [c_LW-1:0] c_LONG_MAX  = c_LW'(LONG_CYCLES);

    localparam logic [NUM_PADS-1:0] c_IDLE_LVL = (ACTIVE_LOW != 0) ? {NUM_PADS{1'b1}}
                                                                   : {NUM_PADS{1'b0}};

    localparam logic [1:0] c_IDLE         = 2'd0;
    localparam logic [1:0] c_PRESS_WAIT   = 2'd1;
    localparam logic [1:0] c_HELD         = 2'd2;
    localparam logic [1:0] c_RELEASE_WAIT = 2'd3;

    localparam logic [1:0] c_EV_PRESS   = 2'b00;
    localparam logic [1:0] c_EV_RELEASE = 2'b01;
    localparam logic [1:0] c_EV_LONG    = 2'b10;

    // ------------------------------------------------------------------------
    // Input conditioning: 2-flop synchroniser, then polarity normalisation
    // ------------------------------------------------------------------------
    logic [NUM_PADS-1:0] r_sync1, r_sync2;
    logic [NUM_PADS-1:0] w_act;

    assign w_act = (ACTIVE_LOW != 0) ? ~r_sync2 : r_sync2;

    // ------------------------------------------------------------------------
    // Per-pad FSM state, counters and event registers
    // ------------------------------------------------------------------------
    logic [1:0]      r_state [NUM_PADS];
    logic [1:0]      w_state_nx [NUM_PADS];
    logic [c_DW-1:0] r_dcnt [NUM_PADS];
    logic [c_DW-1:0] w_dcnt_nx [NUM_PADS];
    logic [c_LW-1:0] r_lcnt [NUM_PADS];
    logic [c_LW-1:0] w_lcnt_nx [NUM_PADS];
    logic [1:0]      r_raise_code [NUM_PADS];
    logic [1:0]      w_raise_code_nx [NUM_PADS];
    logic [1:0]      r_pend_code [NUM_PADS];

    logic [NUM_PADS-1:0] r_pressed, w_pressed_nx;
    logic [NUM_PADS-1:0] r_raise_v, w_raise_v_nx;
    logic [NUM_PADS-1:0] r_defer, w_defer_nx;
    logic [NUM_PADS-1:0] r_pend_v;
    logic [NUM_PADS-1:0] w_long_hit, w_rel_hit, w_press_hit;

    always_comb begin
        for (int p = 0; p < NUM_PADS; p++) begin
            w_state_nx[p]      = r_state[p];
            w_dcnt_nx[p]       = r_dcnt[p];
            w_lcnt_nx[p]       = r_lcnt[p];
            w_pressed_nx[p]    = r_pressed[p];
            w_raise_v_nx[p]    = 1'b0;
            w_raise_code_nx[p] = c_EV_PRESS;
            w_defer_nx[p]      = 1'b0;
            w_long_hit[p]      = 1'b0;
            w_rel_hit[p]       = 1'b0;
            w_press_hit[p]     = 1'b0;

            // Long-press timer runs for the whole time the pad is accepted as touched
            if ((r_state[p] == c_HELD || r_state[p] == c_RELEASE_WAIT) &&
                (r_lcnt[p] != c_LONG_MAX)) begin
                w_lcnt_nx[p]  = r_lcnt[p] + 1'b1;
                w_long_hit[p] = (r_lcnt[p] == c_LONG_LAST);
            end

            case (r_state[p])
                c_IDLE: begin
                    if (w_act[p]) begin
                        w_state_nx[p] = c_PRESS_WAIT;
                        w_dcnt_nx[p]  = c_DCNT_ONE;
                    end
                end
                c_PRESS_WAIT: begin
                    if (!w_act[p]) begin
                        w_state_nx[p] = c_IDLE;
                        w_dcnt_nx[p]  = '0;
                    end else if (r_dcnt[p] == c_DB_LAST) begin
                        w_state_nx[p]   = c_HELD;
                        w_pressed_nx[p] = 1'b1;
                        w_press_hit[p]  = 1'b1;
                        w_lcnt_nx[p]    = '0;
                    end else begin
                        w_dcnt_nx[p] = r_dcnt[p] + 1'b1;
                    end
                end
                c_HELD: begin
                    if (!w_act[p]) begin
                        w_state_nx[p] = c_RELEASE_WAIT;
                        w_dcnt_nx[p]  = c_DCNT_ONE;
                    end
                end
                default: begin // c_RELEASE_WAIT
                    if (w_act[p]) begin
                        w_state_nx[p] = c_HELD;
                        w_dcnt_nx[p]  = '0;
                    end else if (r_dcnt[p] == c_DB_LAST) begin
                        w_state_nx[p]   = c_IDLE;
                        w_pressed_nx[p] = 1'b0;
                        w_rel_hit[p]    = 1'b1;
                    end else begin
                        w_dcnt_nx[p] = r_dcnt[p] + 1'b1;
                    end
                end
            endcase

            // One event per pad per cycle; a RELEASE coinciding with LONG
            // is deferred by one cycle so LONG is reported first.
            if (r_defer[p]) begin
                w_raise_v_nx[p]    = 1'b1;
                w_raise_code_nx[p] = c_EV_RELEASE;
            end else if (w_long_hit[p]) begin
                w_raise_v_nx[p]    = 1'b1;
                w_raise_code_nx[p] = c_EV_LONG;
                w_defer_nx[p]      = w_rel_hit[p];
            end else if (w_rel_hit[p]) begin
                w_raise_v_nx[p]    = 1'b1;
                w_raise_code_nx[p] = c_EV_RELEASE;
            end else if (w_press_hit[p]) begin
                w_raise_v_nx[p]    = 1'b1;
                w_raise_code_nx[p] = c_EV_PRESS;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Arbitration: lowest-index pad with a pending or fresh event wins.
    // A pending event is older than the freshly raised one, so it goes first.
    // ------------------------------------------------------------------------
    logic [NUM_PADS-1:0] w_grant;
    logic                w_push;
    logic [PAD_W-1:0]    w_push_pad;
    logic [1:0]          w_push_code;

    always_comb begin
        w_grant     = '0;
        w_push      = 1'b0;
        w_push_pad  = '0;
        w_push_code = c_EV_PRESS;
        for (int p = 0; p < NUM_PADS; p++) begin
            if (!w_push && (r_pend_v[p] || r_raise_v[p])) begin
                w_push      = 1'b1;
                w_grant[p]  = 1'b1;
                w_push_pad  = PAD_W'(p);
                w_push_code = r_pend_v[p] ? r_pend_code[p] : r_raise_code[p];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1   <= c_IDLE_LVL;
            r_sync2   <= c_IDLE_LVL;
            r_pressed <= '0;
            r_raise_v <= '0;
            r_defer   <= '0;
            r_pend_v  <= '0;
            for (int p = 0; p < NUM_PADS; p++) begin
                r_state[p]      <= c_IDLE;
                r_dcnt[p]       <= '0;
                r_lcnt[p]       <= '0;
                r_raise_code[p] <= c_EV_PRESS;
                r_pend_code[p]  <= c_EV_PRESS;
            end
        end else begin
            r_sync1   <= pad_in;
            r_sync2   <= r_sync1;
            r_pressed <= w_pressed_nx;
            r_raise_v <= w_raise_v_nx;
            r_defer   <= w_defer_nx;
            for (int p = 0; p < NUM_PADS; p++) begin
                r_state[p]      <= w_state_nx[p];
                r_dcnt[p]       <= w_dcnt_nx[p];
                r_lcnt[p]       <= w_lcnt_nx[p];
                r_raise_code[p] <= w_raise_code_nx[p];
                if (w_grant[p]) begin
                    // Pending slot consumed: the fresh event (if any) takes its place
                    r_pend_v[p] <= r_pend_v[p] & r_raise_v[p];
                    if (r_pend_v[p]) begin
                        r_pend_code[p] <= r_raise_code[p];
                    end
                end else if (r_raise_v[p] && !r_pend_v[p]) begin
                    r_pend_v[p]    <= 1'b1;
                    r_pend_code[p] <= r_raise_code[p];
                end
            end
        end
    end

    assign pressed = r_pressed;

    // ------------------------------------------------------------------------
    // Event FIFO: extra pointer bit separates full from empty
    // ------------------------------------------------------------------------
    logic [c_AW:0]    r_wr_ptr, r_rd_ptr;
    logic [PAD_W-1:0] r_mem_pad [FIFO_DEPTH];
    logic [1:0]       r_mem_code [FIFO_DEPTH];
    logic             r_overflow;
    logic             w_empty, w_full, w_pop, w_wr_en;

    assign w_empty = (r_wr_ptr == r_rd_ptr);
    assign w_full  = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign w_pop   = !w_empty && evt.evt_ready;
    // A simultaneous pop frees the head slot, so a full FIFO still accepts
    assign w_wr_en = w_push && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && w_full && !w_pop) begin
                r_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en && !rst) begin
            r_mem_pad[r_wr_ptr[c_AW-1:0]]  <= w_push_pad;
            r_mem_code[r_wr_ptr[c_AW-1:0]] <= w_push_code;
        end
    end

    assign evt.evt_valid = !w_empty;
    assign evt.evt_pad   = w_empty ? '0 : r_mem_pad[r_rd_ptr[c_AW-1:0]];
    assign evt.evt_code  = w_empty ? 2'b00 : r_mem_code[r_rd_ptr[c_AW-1:0]];
    assign overflow      = r_overflow;

endmodule
`default_nettype wire
